port_bus_hub: RTL

Parametrised I/O interconnect and interrupt controller between the KCPSM6 wrapper and up to 8 peripherals (RTC, keyboard, VGA, audio, …). It replaces hand-wired per-peripheral enables and the in_port mux with a page-based address decoder and a registered read-back mux. It adds a vectored, maskable interrupt path with an interrupt/interrupt_ack handshake.

---
 rtl/port_bus_hub.sv | 125 ++++++++++++
 1 files changed

// File: rtl/port_bus_hub.sv
// KCPSM6 I/O hub: page-based port decoder, registered read-back mux and a
// vectored, maskable interrupt controller with an interrupt/interrupt_ack handshake.
module port_bus_hub #(
  parameter int          N_PERIPH  = 4,
  parameter int          PAGE_BITS = 4,
  parameter logic [7:0]  IRQ_EDGE  = 8'hFF
) (
  input  logic                  clk,
  input  logic                  inreset,
  input  logic [7:0]            port_id,
  input  logic                  write_strobe,
  input  logic                  read_strobe,
  input  logic [7:0]            out_port,
  output logic [7:0]            in_port,
  output logic [N_PERIPH-1:0]   act,
  output logic [N_PERIPH-1:0]   periph_wr,
  output logic [N_PERIPH-1:0]   periph_rd,
  input  logic [8*N_PERIPH-1:0] periph_data,
  input  logic [N_PERIPH-1:0]   irq_in,
  output logic                  interrupt,
  input  logic                  interrupt_ack
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  localparam logic [PAGE_BITS-1:0] HUB_PAGE  = '1;
  localparam logic [N_PERIPH-1:0]  EDGE_MODE = IRQ_EDGE[N_PERIPH-1:0];

  logic [PAGE_BITS-1:0] page;
  logic [3:0]           offset;
  logic                 hub_sel;
  logic                 pend_wr;
  logic                 mask_wr;
  logic [N_PERIPH-1:0]  sync1, sync2, irq_prev;
  logic [N_PERIPH-1:0]  pending, mask, masked;
  logic [N_PERIPH-1:0]  set_vec, clr_vec;
  logic [7:0]           source;
  logic [7:0]           rd_data;
  logic                 unused_ok;
  state_t               state, state_next;

  assign page    = port_id[7:8-PAGE_BITS];
  assign offset  = port_id[3:0];
  assign hub_sel = (page == HUB_PAGE);
  assign pend_wr = write_strobe & hub_sel & (offset == 4'h0);
  assign mask_wr = write_strobe & hub_sel & (offset == 4'h1);
  assign unused_ok = ^out_port;

  always_comb begin
    act = '0;
    for (int i = 0; i < N_PERIPH; i++)
      if (page == PAGE_BITS'(i)) act[i] = 1'b1;
  end

  assign periph_wr = {N_PERIPH{write_strobe}} & act;
  assign periph_rd = {N_PERIPH{read_strobe}} & act;

  // Edge channels fire once per synchronised rise; level channels re-assert every
  // cycle the line is high, so a clear only sticks once the level has dropped.
  assign set_vec = (EDGE_MODE & sync2 & ~irq_prev) | (~EDGE_MODE & sync2);
  assign clr_vec = pend_wr ? out_port[N_PERIPH-1:0] : '0;
  assign masked  = pending & mask;

  always_ff @(posedge clk or negedge inreset) begin
    if (!inreset) begin
      sync1    <= '0;
      sync2    <= '0;
      irq_prev <= '0;
      pending  <= '0;
      mask     <= '0;
      in_port  <= 8'h00;
    end else begin
      sync1    <= irq_in;
      sync2    <= sync1;
      irq_prev <= sync2;
      pending  <= set_vec | (pending & ~clr_vec);
      if (mask_wr) mask <= out_port[N_PERIPH-1:0];
      in_port  <= rd_data;
    end
  end

  always_comb begin
    source = 8'hFF;
    for (int i = N_PERIPH - 1; i >= 0; i--)
      if (masked[i]) source = 8'(i);
  end

  always_comb begin
    rd_data = 8'h00;
    if (hub_sel) begin
      case (offset)
        4'h0:    rd_data[N_PERIPH-1:0] = pending;
        4'h1:    rd_data[N_PERIPH-1:0] = mask;
        4'h2:    rd_data = source;
        4'h3:    rd_data = {4'hA, 4'(N_PERIPH)};
        default: rd_data = 8'h00;
      endcase
    end else begin
      for (int i = 0; i < N_PERIPH; i++)
        if (act[i]) rd_data = periph_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge inreset) begin
    if (!inreset) state <= IDLE;
    else          state <= state_next;
  end

  // A mask write that empties PENDING&MASK withdraws an unacknowledged request.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|masked) state_next = REQ;
      REQ:     if (interrupt_ack) state_next = SERVICE;
               else if (!(|masked)) state_next = IDLE;
      SERVICE: if (pend_wr) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    interrupt = (state == REQ);
  end

endmodule
